csla_flag_stage: RTL and testbench
==================================

# csla_flag_stage

Registered result/flag stage directly downstream of the carry-select adder mux. Captures the selected 32-bit sum with its carry (C) and overflow (V), derives negative (N) and zero (Z), and resolves the RISC-V branch condition for the operation. Uses a 2-entry skid buffer with a valid/ready handshake on both sides, so the adder path is decoupled from the consumer's stalls.

## Interface
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `CNT_W`, 16: width of the overflow event counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept. Registered.
- `in_result` in WIDTH: selected sum from the CSLA mux.
- `in_c` in 1: carry out.
- `in_v` in 1: signed overflow.
- `in_cmp_op` in 3: RISC-V branch funct3 for the operation.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer accepts the head entry.
- `out_result` out WIDTH: registered result.
- `out_n`, `out_z`, `out_c`, `out_v` out 1 each: registered flags.
- `out_taken` out 1: branch condition for the head entry.
- `ovf_clr` in 1: synchronous clear of the overflow counter.
- `ovf_count` out CNT_W: saturating count of accepted entries with V=1.

## Operation
- Handshake rules:
  - Input accept = `in_valid & in_ready`.
  - Output pop = `out_valid & out_ready`.
  - Payload inputs are don't-care when `in_valid` = 0.
- Flags are computed when an entry is captured and stored with it:
  - N = `in_result[31]`.
  - Z = (`in_result` == 0).
  - C = `in_c`, V = `in_v`.
- Branch resolution assumes upstream computed a−b as a+~b+1. C=1 means a≥b unsigned.
  - 000 (BEQ): taken = Z.
  - 001 (BNE): taken = !Z.
  - 100 (BLT): taken = N^V.
  - 101 (BGE): taken = !(N^V).
  - 110 (BLTU): taken = !C.
  - 111 (BGEU): taken = C.
  - 010 and 011: taken = 0.
- Skid state machine:
  - EMPTY: accept → ONE (head loaded).
  - ONE, accept without pop → TWO (skid loaded).
  - ONE, accept with pop → ONE (head replaced by the new entry).
  - ONE, pop without accept → EMPTY.
  - TWO: `in_ready` = 0. Pop → ONE, skid moves to head. No accept is possible.
- `in_ready` = (next state != TWO), registered.
- `out_valid` = (state != EMPTY).
- Entries leave in strict FIFO order. No entry is dropped or duplicated.
- Reset, including mid-operation: all state is discarded immediately.

## Timing
- Latency: an entry accepted at edge k is visible on `out_*` after edge k, with `out_valid` = 1 in cycle k+1. This holds when the stage was EMPTY, or was ONE with a pop at edge k.
- Full throughput: one entry per cycle while `out_ready` = 1.
- A stall of one cycle is absorbed by the skid entry. `in_ready` drops in the cycle after the second entry is captured.
- Output payload and flags stay stable while `out_valid` = 1 and `out_ready` = 0.
- Reset values while `rst_n` = 0, all asynchronous:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_result` = 0, `out_n`/`out_z`/`out_c`/`out_v` = 0, `out_taken` = 0.
  - `ovf_count` = 0, state = EMPTY.
- Inputs are ignored while `rst_n` = 0.
- `ovf_count`:
  - Increments by 1 at the edge where an entry with `in_v` = 1 is accepted.
  - Saturates at all-ones and does not wrap.
  - `ovf_clr` and an increment in the same cycle: clear wins, result 0.

## Configuration
- `CSLA_OVF_CNT_EN`:
  - Defined: the overflow counter is built as described.
  - Undefined: no counter flops are built. `ovf_count` is tied to 0 and `ovf_clr` is ignored. The port list is unchanged.
- The handshake and flag behaviour are identical in both builds.

## Test plan
- Reset/latency: hold `rst_n` = 0, check all outputs match the reset values. Release, send result=0x00000000, C=1, V=0, op=000 with `out_ready` = 1 → next cycle `out_valid` = 1, Z=1, N=0, C=1, `out_taken` = 1.
- Signed and unsigned compares:
  - 5−7 (result 0xFFFFFFFE, C=0, V=0), op=100 → taken=1.
  - Same entry with op=110 → taken=1.
  - Same entry with op=111 → taken=0.
  - Overflow case: 0x80000000−1 (result 0x7FFFFFFF, C=1, V=1), op=100 → taken=1 and N=0.
- Stall/skid: send 3 back-to-back entries A, B, C with `out_ready` = 0 → A held on the output, B captured, `in_ready` = 0, C not accepted. Raise `out_ready` → A, B, C pop in order, with no loss and no duplicates.
- Streaming: 100 random entries with `out_ready` toggled randomly → output order, payload and flags match a reference model. No handshake violations.
- Reset mid-operation: assert `rst_n` while in TWO → outputs go to the reset values immediately, without waiting for a clock edge. After release, `in_ready` = 1 and no stale entry appears.
- Counter (with `CSLA_OVF_CNT_EN`):
  - Preload near saturation with 0xFFFF V=1 accepts, then send 3 more → count stays 0xFFFF.
  - Assert `ovf_clr` in the same cycle as a V=1 accept → count = 0.
  - Without the macro → count stays 0 throughout.

Source files
------------

// File: rtl/csla_flag_stage.sv
// csla_flag_stage: registered result/flag stage behind the carry-select adder mux,
// latency: 1 cycle (entry accepted at edge k is on out_* in cycle k+1),
// backpressure: 2-entry skid buffer; in_ready is registered and drops once both entries are occupied.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake (in_ready registered)
//   in_result, in_c, in_v : selected sum, carry out, signed overflow
//   in_cmp_op             : RISC-V branch funct3 of the operation
//   out_valid / out_ready : downstream handshake for the head entry
//   out_result, out_n/z/c/v, out_taken : registered head payload, flags and branch outcome
//   ovf_clr, ovf_count    : synchronous clear and saturating count of accepted V=1 entries
//
// Build option: define CSLA_OVF_CNT_EN to build the overflow event counter. Without it
// ovf_count is tied to zero, ovf_clr is ignored and no counter flops exist.

module csla_flag_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_c,
    input  logic             in_v,
    input  logic [2:0]       in_cmp_op,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic             out_taken,

    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    // One buffered entry: payload plus everything derived from it at capture time,
    // so the output side never recomputes anything from the head register.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
        logic             taken;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    // Branch condition from flags of a+~b+1. C=1 means a >= b unsigned;
    // N^V is the true sign of the signed difference.
    function automatic logic branch_taken(
        input logic [2:0] op,
        input logic       n,
        input logic       z,
        input logic       c,
        input logic       v
    );
        logic t;
        case (op)
            3'b000:  t = z;          // BEQ
            3'b001:  t = ~z;         // BNE
            3'b100:  t = n ^ v;      // BLT
            3'b101:  t = ~(n ^ v);   // BGE
            3'b110:  t = ~c;         // BLTU
            3'b111:  t = c;          // BGEU
            default: t = 1'b0;       // 010/011 are not branch encodings
        endcase
        return t;
    endfunction

    state_e state_q, state_d;
    entry_t head_q,  head_d;
    entry_t skid_q,  skid_d;
    logic   in_ready_q;
    logic   out_valid_q;

    entry_t in_entry;
    logic   accept;
    logic   pop;

    // Flags are formed here, once, on the way in.
    always_comb begin
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.n      = in_result[WIDTH-1];
        in_entry.z      = (in_result == '0);
        in_entry.c      = in_c;
        in_entry.v      = in_v;
        in_entry.taken  = branch_taken(in_cmp_op, in_result[WIDTH-1],
                                       (in_result == '0), in_c, in_v);
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Skid control. The head register always holds the oldest entry; the skid
    // register is only meaningful in S_TWO and refills the head on the next pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        skid_d  = in_entry;
                        state_d = S_TWO;
                    end
                    2'b11: begin
                        // Head leaves and is replaced in the same edge: full throughput.
                        head_d  = in_entry;
                    end
                    2'b01: begin
                        state_d = S_EMPTY;
                    end
                    default: begin
                    end
                endcase
            end
            S_TWO: begin
                // in_ready is low here, so accept cannot occur.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // in_ready and out_valid are registered from the next state so neither
    // handshake output has a combinational path from the opposite side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != S_TWO);
            out_valid_q <= (state_d != S_EMPTY);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = head_q.result;
    assign out_n      = head_q.n;
    assign out_z      = head_q.z;
    assign out_c      = head_q.c;
    assign out_v      = head_q.v;
    assign out_taken  = head_q.taken;

`ifdef CSLA_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = '0;
        end else if (accept && in_v && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_count      = '0;
`endif

endmodule

// File: tb/tb_csla_flag_stage.sv
// tb_csla_flag_stage: scoreboard bench for csla_flag_stage,
// expected entries are queued on accept and compared while they sit at the head,
// backpressure is exercised with out_ready held low and toggled randomly.

module tb_csla_flag_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_c;
    logic        in_v;
    logic [2:0]  in_cmp_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_n;
    logic        out_z;
    logic        out_c;
    logic        out_v;
    logic        out_taken;
    logic        ovf_clr;
    logic [15:0] ovf_count;

    csla_flag_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_c       (in_c),
        .in_v       (in_v),
        .in_cmp_op  (in_cmp_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_n      (out_n),
        .out_z      (out_z),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_taken  (out_taken),
        .ovf_clr    (ovf_clr),
        .ovf_count  (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    logic [36:0] sb_q[$];
    logic [15:0] cnt_m = '0;
    bit          stream_on;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {result, N, Z, C, V, taken}
    function automatic logic [36:0] model(input logic [31:0] r, input logic c,
                                          input logic v, input logic [2:0] op);
        logic n, z, t;
        n = r[31];
        z = (r == 32'h0);
        case (op)
            3'b000:  t = z;
            3'b001:  t = !z;
            3'b100:  t = n ^ v;
            3'b101:  t = !(n ^ v);
            3'b110:  t = !c;
            3'b111:  t = c;
            default: t = 1'b0;
        endcase
        return {r, n, z, c, v, t};
    endfunction

    // Monitor: compares outputs against the model occupancy and queue head,
    // then applies this cycle's pop/accept to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            cnt_m = '0;
        end else begin
            bit m_in_rdy;
            m_in_rdy = (sb_q.size() < 2);
            chk("in_ready", in_ready, m_in_rdy);
            chk("out_valid", out_valid, sb_q.size() != 0);
            if (sb_q.size() != 0)
                chk("head", {out_result, out_n, out_z, out_c, out_v, out_taken}, sb_q[0]);
            chk("ovf_count", ovf_count, cnt_m);
`ifdef CSLA_OVF_CNT_EN
            if (ovf_clr) cnt_m = '0;
            else if (in_valid && m_in_rdy && in_v && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
            if (out_ready && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                n_pop++;
            end
            if (in_valid && m_in_rdy) begin
                sb_q.push_back(model(in_result, in_c, in_v, in_cmp_op));
                n_push++;
            end
        end
    end

    // Present one entry at posedge+1 and hold it until accepted; returns at posedge+1
    // just after the accepting edge.
    task automatic send(input logic [31:0] r, input logic c, input logic v, input logic [2:0] op);
        int waited = 0;
        bit done = 0;
        in_valid  = 1'b1;
        in_result = r;
        in_c      = c;
        in_v      = v;
        in_cmp_op = op;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else begin
                waited++;
                if (waited > 200) begin
                    chk("send_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_flags"}, {out_n, out_z, out_c, out_v, out_taken}, 0);
        chk({tag, "_ovf_count"}, ovf_count, 0);
    endtask

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic [2:0]  op;
        logic        taken;
        string       tag;
    } cmp_vec_t;

    initial begin
        watchdog();
    end

    task automatic watchdog();
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    endtask

    initial begin
        cmp_vec_t vecs[$];
        int p0, h0;

        rst_n     = 1'b0;
        in_valid  = 1'b1;          // ignored during reset
        in_result = 32'hDEAD_BEEF;
        in_c      = 1'b1;
        in_v      = 1'b1;
        in_cmp_op = 3'b111;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        stream_on = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // First entry latency: visible in the cycle after the accepting edge.
        out_ready = 1'b1;
        send(32'h0, 1'b1, 1'b0, 3'b000);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_z", out_z, 1);
        chk("lat_n", out_n, 0);
        chk("lat_c", out_c, 1);
        chk("lat_taken", out_taken, 1);

        // Compare resolution.
        vecs.push_back('{32'hFFFF_FFFE, 1'b0, 1'b0, 3'b100, 1'b1, "blt_5_7"});
        vecs.push_back('{32'hFFFF_FFFE, 1'b0, 1'b0, 3'b110, 1'b1, "bltu_5_7"});
        vecs.push_back('{32'hFFFF_FFFE, 1'b0, 1'b0, 3'b111, 1'b0, "bgeu_5_7"});
        vecs.push_back('{32'hFFFF_FFFE, 1'b0, 1'b0, 3'b101, 1'b0, "bge_5_7"});
        vecs.push_back('{32'h7FFF_FFFF, 1'b1, 1'b1, 3'b100, 1'b1, "blt_ovf"});
        vecs.push_back('{32'h0000_0000, 1'b1, 1'b0, 3'b001, 1'b0, "bne_eq"});
        vecs.push_back('{32'h0000_0003, 1'b1, 1'b0, 3'b000, 1'b0, "beq_ne"});
        vecs.push_back('{32'h0000_0000, 1'b1, 1'b0, 3'b010, 1'b0, "op010"});
        vecs.push_back('{32'h0000_0000, 1'b1, 1'b0, 3'b011, 1'b0, "op011"});
        foreach (vecs[i]) begin
            send(vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].op);
            chk({vecs[i].tag, "_taken"}, out_taken, vecs[i].taken);
        end
        chk("blt_ovf_n_seen", vecs[4].r[31], 0);
        drain();

        // Stall / skid: A held, B in skid, C refused.
        out_ready = 1'b0;
        p0 = n_pop;
        send(32'hAAAA_0001, 1'b0, 1'b0, 3'b000);
        send(32'hBBBB_0002, 1'b1, 1'b0, 3'b001);
        in_valid  = 1'b1;
        in_result = 32'hCCCC_0003;
        in_c      = 1'b1;
        in_v      = 1'b0;
        in_cmp_op = 3'b111;
        chk("stall_in_ready_now", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head_a", out_result, 32'hAAAA_0001);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'hCCCC_0003, 1'b1, 1'b0, 3'b111);
        drain();
        chk("stall_pops", n_pop - p0, 3);

        // Random streaming with random backpressure.
        p0 = n_pop;
        h0 = n_push;
        stream_on = 1'b1;
        fork
            begin
                while (stream_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [31:0] r;
                    case ($urandom_range(0, 7))
                        0:       r = 32'h0;
                        1:       r = 32'h8000_0000;
                        default: r = $urandom;
                    endcase
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)));
                end
                stream_on = 1'b0;
            end
        join
        drain();
        chk("stream_pushes", n_push - h0, 100);
        chk("stream_pops", n_pop - p0, 100);

        // Reset while two entries are held.
        out_ready = 1'b0;
        send(32'h1234_5678, 1'b1, 1'b1, 3'b100);
        send(32'h9ABC_DEF0, 1'b0, 1'b1, 3'b101);
        chk("pre_rst_full", in_ready, 0);
        in_valid  = 1'b1;
        in_result = 32'h5555_5555;
        rst_n     = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(32'h0000_0042, 1'b0, 1'b0, 3'b110);
        chk("post_rst_fresh", out_result, 32'h0000_0042);
        drain();

`ifdef CSLA_OVF_CNT_EN
        // Saturation: 0xFFFF V=1 accepts, then 3 more.
        out_ready = 1'b1;
        for (int i = 0; i < 65535 + 3; i++) send(32'h1, 1'b1, 1'b1, 3'b000);
        chk("ovf_saturated", ovf_count, 16'hFFFF);
        // Clear wins over a same-cycle increment.
        ovf_clr = 1'b1;
        send(32'h2, 1'b1, 1'b1, 3'b000);
        ovf_clr = 1'b0;
        chk("ovf_clr_wins", ovf_count, 0);
        send(32'h3, 1'b1, 1'b1, 3'b000);
        chk("ovf_inc_after_clr", ovf_count, 1);
        send(32'h4, 1'b1, 1'b0, 3'b000);
        chk("ovf_no_inc_v0", ovf_count, 1);
`else
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(32'h1, 1'b1, 1'b1, 3'b000);
        chk("ovf_tied_zero", ovf_count, 0);
        ovf_clr = 1'b1;
        send(32'h2, 1'b1, 1'b1, 3'b000);
        ovf_clr = 1'b0;
        chk("ovf_tied_zero_clr", ovf_count, 0);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
